// File: rtl/cpu_ad48_timer_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu_ad48_timer_unit_pkg
// Brief   : Register selects, CTRL field positions and reset constants
// Rev     : 1.0
// ============================================================================
package cpu_ad48_timer_unit_pkg;

    typedef enum logic [1:0] {
        TMR_SEL_TIMER    = 2'd0,
        TMR_SEL_CMP      = 2'd1,
        TMR_SEL_CTRL     = 2'd2,
        TMR_SEL_INTERVAL = 2'd3
    } tmr_sel_e;

    localparam int TMR_CTRL_EN        = 0;
    localparam int TMR_CTRL_AR        = 1;
    localparam int TMR_CTRL_PRESC_LSB = 8;

    localparam logic TMR_RST_EN = 1'b1;
    localparam logic TMR_RST_AR = 1'b0;

endpackage : cpu_ad48_timer_unit_pkg
`default_nettype wire

// File: rtl/cpu_ad48_timer_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : cpu_ad48_timer_unit_if
// Brief     : CSR write/read port and interrupt lines of the machine timer
// Rev       : 1.0
// ============================================================================
interface cpu_ad48_timer_unit_if #(
    parameter int XLEN = 48
);
    logic            csr_we;
    logic [1:0]      csr_sel;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            irq_ack;
    logic            irq_pending;
    logic            tick;
    logic [XLEN-1:0] timer;
    logic [XLEN-1:0] timer_cmp;

    modport master (
        output csr_we, csr_sel, csr_wdata, irq_ack,
        input  csr_rdata, irq_pending, tick, timer, timer_cmp
    );

    modport slave (
        input  csr_we, csr_sel, csr_wdata, irq_ack,
        output csr_rdata, irq_pending, tick, timer, timer_cmp
    );
endinterface : cpu_ad48_timer_unit_if
`default_nettype wire

// File: rtl/cpu_ad48_prescaler.sv
`default_nettype none
// ============================================================================
// Module : cpu_ad48_prescaler
// Brief  : Divide-by-(divisor+1) phase counter producing the timer step strobe
// Rev    : 1.0
// ============================================================================
module cpu_ad48_prescaler #(
    parameter int PRESC_W = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               enable,
    input  wire logic               clear,
    input  wire logic               suppress,
    input  wire logic [PRESC_W-1:0] divisor,
    output logic                    step,
    output logic                    tick
);
    localparam logic [PRESC_W-1:0] c_cnt_one = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] r_cnt;
    logic               w_wrap;

    assign w_wrap = (r_cnt == divisor);
    // A restart of the phase (clear) swallows any step due in the same cycle.
    assign step   = enable && !clear && w_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= step && !suppress;
            if (clear) begin
                r_cnt <= '0;
            end else if (enable) begin
                r_cnt <= w_wrap ? '0 : r_cnt + c_cnt_one;
            end
        end
    end

endmodule : cpu_ad48_prescaler
`default_nettype wire

// File: rtl/cpu_ad48_timer_unit.sv
`default_nettype none
// ============================================================================
// Module : cpu_ad48_timer_unit
// Brief  : Machine timer with compare, periodic reload and sticky interrupt
// Rev    : 1.0
// ============================================================================
module cpu_ad48_timer_unit
    import cpu_ad48_timer_unit_pkg::*;
#(
    parameter int              XLEN      = 48,
    parameter int              PRESC_W   = 8,
    parameter logic [XLEN-1:0] CMP_RESET = {XLEN{1'b1}}
) (
    input  wire logic              clk,
    input  wire logic              reset,
    cpu_ad48_timer_unit_if.slave   bus
);
    localparam logic [XLEN-1:0] c_timer_one = {{(XLEN-1){1'b0}}, 1'b1};

    logic [XLEN-1:0]    r_timer;
    logic [XLEN-1:0]    r_cmp;
    logic [XLEN-1:0]    r_interval;
    logic               r_enable;
    logic               r_auto_reload;
    logic [PRESC_W-1:0] r_prescale;
    logic               r_armed;
    logic               r_pending;

    tmr_sel_e           w_sel;
    logic               w_wr_timer;
    logic               w_wr_cmp;
    logic               w_wr_ctrl;
    logic               w_wr_interval;
    logic               w_step;
    logic               w_tick;
    logic               w_fire;
    logic [XLEN-1:0]    w_ctrl_rd;
    logic [XLEN-1:0]    w_rdata;

    assign w_sel         = tmr_sel_e'(bus.csr_sel);
    assign w_wr_timer    = bus.csr_we && (w_sel == TMR_SEL_TIMER);
    assign w_wr_cmp      = bus.csr_we && (w_sel == TMR_SEL_CMP);
    assign w_wr_ctrl     = bus.csr_we && (w_sel == TMR_SEL_CTRL);
    assign w_wr_interval = bus.csr_we && (w_sel == TMR_SEL_INTERVAL);

    // A fresh compare value is not trusted until it has been registered.
    assign w_fire = r_armed && (r_timer >= r_cmp) && !w_wr_cmp;

    cpu_ad48_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (r_enable),
        .clear    (w_wr_ctrl),
        .suppress (w_wr_timer),
        .divisor  (r_prescale),
        .step     (w_step),
        .tick     (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer       <= '0;
            r_cmp         <= CMP_RESET;
            r_interval    <= '0;
            r_enable      <= TMR_RST_EN;
            r_auto_reload <= TMR_RST_AR;
            r_prescale    <= '0;
            r_armed       <= 1'b0;
            r_pending     <= 1'b0;
        end else begin
            if (w_wr_timer) begin
                r_timer <= bus.csr_wdata;
            end else if (w_step) begin
                r_timer <= r_timer + c_timer_one;
            end

            if (w_wr_cmp) begin
                r_cmp   <= bus.csr_wdata;
                r_armed <= 1'b1;
            end else if (w_fire) begin
                if (r_auto_reload) begin
                    r_cmp <= r_cmp + r_interval;
                end else begin
                    r_armed <= 1'b0;
                end
            end

            if (w_wr_ctrl) begin
                r_enable      <= bus.csr_wdata[TMR_CTRL_EN];
                r_auto_reload <= bus.csr_wdata[TMR_CTRL_AR];
                r_prescale    <= bus.csr_wdata[TMR_CTRL_PRESC_LSB +: PRESC_W];
            end

            if (w_wr_interval) begin
                r_interval <= bus.csr_wdata;
            end

            // Fire beats a simultaneous acknowledge so no request is lost.
            if (w_fire) begin
                r_pending <= 1'b1;
            end else if (bus.irq_ack) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_ctrl_rd                                   = '0;
        w_ctrl_rd[TMR_CTRL_EN]                      = r_enable;
        w_ctrl_rd[TMR_CTRL_AR]                      = r_auto_reload;
        w_ctrl_rd[TMR_CTRL_PRESC_LSB +: PRESC_W]    = r_prescale;
    end

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            TMR_SEL_TIMER:    w_rdata = r_timer;
            TMR_SEL_CMP:      w_rdata = r_cmp;
            TMR_SEL_CTRL:     w_rdata = w_ctrl_rd;
            TMR_SEL_INTERVAL: w_rdata = r_interval;
            default:          w_rdata = '0;
        endcase
    end

    assign bus.csr_rdata   = w_rdata;
    assign bus.irq_pending = r_pending;
    assign bus.tick        = w_tick;
    assign bus.timer       = r_timer;
    assign bus.timer_cmp   = r_cmp;

endmodule : cpu_ad48_timer_unit
`default_nettype wire

// File: tb/tb_cpu_ad48_timer_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_ad48_timer_unit
// Brief  : Self-checking bench: readback table, directed corners, random run
// Rev    : 1.0
// ============================================================================
module tb_cpu_ad48_timer_unit;

    localparam logic [47:0] MAXV = 48'hFFFF_FFFF_FFFF;

    logic clk;
    logic reset;

    cpu_ad48_timer_unit_if #(.XLEN(48)) bus ();

    cpu_ad48_timer_unit #(
        .XLEN      (48),
        .PRESC_W   (8),
        .CMP_RESET (MAXV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle-level reference: the timer state in plain arithmetic terms.
    typedef struct {
        logic [47:0] timer;
        logic [47:0] cmp;
        logic [47:0] interval;
        logic        en;
        logic        ar;
        int          presc;
        int          phase;
        logic        armed;
        logic        pend;
        logic        tick;
    } model_t;

    typedef struct {
        logic [1:0]  sel;
        logic [47:0] wdata;
        logic [47:0] exp_rd;
    } vec_t;

    model_t m;
    vec_t   vecs[5];
    int     n_checks;
    int     n_errors;
    int     n;
    int     ticks;
    logic   seen;
    logic   stayed;
    logic [47:0] t0;
    logic [63:0] rnd;

    function automatic model_t model_next(model_t s, logic rst, logic we,
                                          logic [1:0] sel, logic [47:0] wd, logic ack);
        model_t nx;
        logic   restart, wr_t, wr_c, inc, fire;
        nx = s;
        if (rst) begin
            nx.timer = '0; nx.cmp = MAXV; nx.interval = '0;
            nx.en = 1'b1; nx.ar = 1'b0; nx.presc = 0; nx.phase = 0;
            nx.armed = 1'b0; nx.pend = 1'b0; nx.tick = 1'b0;
            return nx;
        end
        restart = we && (sel == 2'd2);
        wr_t    = we && (sel == 2'd0);
        wr_c    = we && (sel == 2'd1);
        inc     = s.en && !restart && (s.phase == s.presc);
        if (restart)   nx.phase = 0;
        else if (s.en) nx.phase = (s.phase + 1) % (s.presc + 1);
        fire     = s.armed && (s.timer >= s.cmp) && !wr_c;
        nx.timer = wr_t ? wd : s.timer + 48'(inc);
        nx.tick  = inc && !wr_t;
        if (wr_c) begin
            nx.cmp = wd; nx.armed = 1'b1;
        end else if (fire) begin
            if (s.ar) nx.cmp = s.cmp + s.interval;
            else      nx.armed = 1'b0;
        end
        if (restart) begin
            nx.en = wd[0]; nx.ar = wd[1]; nx.presc = int'(wd[15:8]);
        end
        if (we && sel == 2'd3) nx.interval = wd;
        nx.pend = fire ? 1'b1 : (s.pend && !ack);
        return nx;
    endfunction

    function automatic logic [47:0] model_read(model_t s, logic [1:0] sel);
        case (sel)
            2'd0:    return s.timer;
            2'd1:    return s.cmp;
            2'd2:    return {32'd0, 8'(s.presc), 6'd0, s.ar, s.en};
            default: return s.interval;
        endcase
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic w, input logic [1:0] s, input logic [47:0] d, input logic a);
        bus.csr_we    = w;
        bus.csr_sel   = s;
        bus.csr_wdata = d;
        bus.irq_ack   = a;
        @(posedge clk);
        m = model_next(m, reset, w, s, d, a);
        #1;
        check("timer",       bus.timer,       m.timer);
        check("timer_cmp",   bus.timer_cmp,   m.cmp);
        check("irq_pending", 48'(bus.irq_pending), 48'(m.pend));
        check("tick",        48'(bus.tick),   48'(m.tick));
        check("csr_rdata",   bus.csr_rdata,   model_read(m, s));
    endtask

    task automatic idle(input logic a);
        step(1'b0, 2'd0, 48'd0, a);
    endtask

    task automatic wr(input logic [1:0] s, input logic [47:0] d);
        step(1'b1, s, d, 1'b0);
    endtask

    task automatic wait_pend(input int max, input logic a, output int cnt, output logic hit);
        cnt = 0;
        hit = bus.irq_pending;
        while (!hit && cnt < max) begin
            idle(a);
            cnt++;
            hit = bus.irq_pending;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.csr_we = 1'b0; bus.csr_sel = 2'd0; bus.csr_wdata = '0; bus.irq_ack = 1'b0;
        idle(1'b0);
        reset = 1'b0;
        check("rst_timer",   bus.timer,     48'd0);
        check("rst_cmp",     bus.timer_cmp, MAXV);
        check("rst_pending", 48'(bus.irq_pending), 48'd0);
        step(1'b0, 2'd2, 48'd0, 1'b0);
        check("rst_ctrl",    bus.csr_rdata, 48'd1);

        // Register readback table
        vecs[0] = '{2'd2, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_FF03};
        vecs[1] = '{2'd2, 48'h0000_0000_0001, 48'h0000_0000_0001};
        vecs[2] = '{2'd3, 48'h1234_5678_9ABC, 48'h1234_5678_9ABC};
        vecs[3] = '{2'd1, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF};
        vecs[4] = '{2'd2, 48'hABCD_0000_0501, 48'h0000_0000_0501};
        for (int i = 0; i < 5; i++) begin
            wr(vecs[i].sel, vecs[i].wdata);
            step(1'b0, vecs[i].sel, 48'd0, 1'b0);
            check("table_rd", bus.csr_rdata, vecs[i].exp_rd);
        end

        // One-shot compare at 12 with prescale 0
        wr(2'd2, 48'h1);
        wr(2'd3, 48'd0);
        wr(2'd0, 48'd0);
        wr(2'd1, 48'd12);
        wait_pend(60, 1'b0, n, seen);
        check("oneshot_seen",  48'(seen), 48'd1);
        check("oneshot_timer", bus.timer, 48'd13);

        // Ack, stay quiet 200 cycles, re-arm at timer+64
        idle(1'b1);
        stayed = 1'b1;
        for (int i = 0; i < 200; i++) begin
            idle(1'b0);
            if (bus.irq_pending) stayed = 1'b0;
        end
        check("ack_quiet", 48'(stayed), 48'd1);
        wr(2'd1, m.timer + 48'd64);
        wait_pend(200, 1'b0, n, seen);
        check("rearm_latency", 48'(n + 1), 48'd65);

        // Auto-reload every 64 counts
        idle(1'b1);
        wr(2'd2, 48'h3);
        wr(2'd3, 48'd64);
        wr(2'd0, 48'd0);
        wr(2'd1, 48'd12);
        for (int k = 0; k < 3; k++) begin
            wait_pend(200, 1'b0, n, seen);
            check("ar_seen",  48'(seen), 48'd1);
            check("ar_timer", bus.timer, 48'(13 + 64 * k));
            check("ar_cmp",   bus.timer_cmp, 48'(76 + 64 * k));
            idle(1'b1);
        end

        // Prescale 3: one count per 4 cycles, CTRL write restarts the phase
        wr(2'd2, 48'h0301);
        wr(2'd0, 48'd0);
        t0 = m.timer;
        ticks = 0;
        for (int i = 0; i < 16; i++) begin
            idle(1'b0);
            if (bus.tick) ticks++;
        end
        check("presc_timer", bus.timer, t0 + 48'd4);
        check("presc_ticks", 48'(ticks), 48'd4);
        n = 0;
        while (!bus.tick && n < 8) begin
            idle(1'b0);
            n++;
        end
        check("presc_tick_found", 48'(bus.tick), 48'd1);
        idle(1'b0);
        wr(2'd2, 48'h0301);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            idle(1'b0);
            n++;
            seen = bus.tick;
        end
        check("presc_restart", 48'(n), 48'd4);

        // Compare below timer fires on the first evaluated cycle
        idle(1'b1);
        wr(2'd2, 48'h1);
        wr(2'd0, 48'hFFFF_FFFF_FFFE);
        wr(2'd1, 48'd1);
        check("below_suppressed", 48'(bus.irq_pending), 48'd0);
        idle(1'b0);
        check("below_fire", 48'(bus.irq_pending), 48'd1);

        // Compare at max: fire, wrap, no re-fire
        idle(1'b1);
        wr(2'd0, 48'hFFFF_FFFF_FFFE);
        wr(2'd1, MAXV);
        idle(1'b0);
        check("wrap_fire",  48'(bus.irq_pending), 48'd1);
        check("wrap_timer", bus.timer, 48'd0);
        idle(1'b1);
        stayed = 1'b1;
        for (int i = 0; i < 20; i++) begin
            idle(1'b0);
            if (bus.irq_pending) stayed = 1'b0;
        end
        check("wrap_no_refire", 48'(stayed), 48'd1);

        // Ack held while the fire happens
        wr(2'd0, 48'd0);
        wr(2'd1, 48'd5);
        wait_pend(20, 1'b1, n, seen);
        check("ackfire_seen",  48'(seen), 48'd1);
        check("ackfire_timer", bus.timer, 48'd6);

        // Reset in the middle of counting
        wr(2'd2, 48'h0303);
        wr(2'd3, 48'd7);
        for (int i = 0; i < 5; i++) idle(1'b0);
        reset = 1'b1;
        idle(1'b0);
        reset = 1'b0;
        check("mid_rst_timer",   bus.timer,     48'd0);
        check("mid_rst_cmp",     bus.timer_cmp, MAXV);
        check("mid_rst_pending", 48'(bus.irq_pending), 48'd0);
        check("mid_rst_tick",    48'(bus.tick), 48'd0);
        step(1'b0, 2'd2, 48'd0, 1'b0);
        check("mid_rst_ctrl", bus.csr_rdata, 48'd1);
        step(1'b0, 2'd3, 48'd0, 1'b0);
        check("mid_rst_interval", bus.csr_rdata, 48'd0);

        // Disabled timer stays frozen
        wr(2'd2, 48'h0);
        t0 = m.timer;
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            idle(1'b0);
            if (bus.tick) ticks++;
        end
        check("frozen_timer", bus.timer, t0);
        check("frozen_ticks", 48'(ticks), 48'd0);
        wr(2'd2, 48'h1);

        // Randomised traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic        w;
            logic [1:0]  s;
            logic [47:0] d;
            int          r;
            r = int'($urandom_range(0, 199));
            reset = (r == 0);
            w = (r < 30);
            s = 2'($urandom_range(0, 3));
            rnd = {$urandom(), $urandom()};
            case (s)
                2'd0: d = ($urandom_range(0, 3) == 0) ? rnd[47:0] : m.timer + 48'($urandom_range(0, 40));
                2'd1: d = m.timer + 48'($urandom_range(0, 60)) - 48'd4;
                2'd2: d = {rnd[47:16], 6'd0, 2'($urandom_range(0, 3)), 6'd0,
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0)};
                default: d = 48'($urandom_range(0, 80));
            endcase
            step(w, s, d, $urandom_range(0, 3) == 0);
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_cpu_ad48_timer_unit
`default_nettype wire
